fir_stream_ctrl: RTL

- Frame-based sequencer for the 4-tap Q1.7 FIR filter `filtro_fir`.
- Accepts a valid/ready sample stream and drives the filter's `i_is_data`, `i_en` and `i_srst` inputs. Captures the filter's combinational output into a registered, backpressured output stream.
- Per frame: passes N samples, optionally drains the filter tail with zero samples, then clears the filter delay line.

---
 rtl/fir_stream_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/fir_stream_ctrl.sv
// Frame sequencer for the 4-tap Q1.7 FIR filter: feeds N samples, optionally drains the
// tail with zeros (FIR_CTRL_TAIL_FLUSH_EN), clears the delay line and registers the output.
module fir_stream_ctrl #(
  parameter int NB_DATA = 8,
  parameter int NB_LEN  = 16,
  parameter int N_TAPS  = 4
) (
  input  logic               clk,
  input  logic               i_srst,
  input  logic               i_start,
  input  logic [NB_LEN-1:0]  i_frame_len,
  output logic               o_busy,
  output logic               o_done,
  input  logic [NB_DATA-1:0] i_s_data,
  input  logic               i_s_valid,
  output logic               o_s_ready,
  output logic [NB_DATA-1:0] o_fir_data,
  output logic               o_fir_en,
  output logic               o_fir_srst,
  input  logic [NB_DATA-1:0] i_fir_data,
  output logic [NB_DATA-1:0] o_m_data,
  output logic               o_m_valid,
  output logic               o_m_last,
  input  logic               i_m_ready
);

  if (N_TAPS < 2) begin : g_taps_chk
    $error("fir_stream_ctrl: N_TAPS must be at least 2");
  end

`ifdef FIR_CTRL_TAIL_FLUSH_EN
  typedef enum logic [1:0] {CLEAR, IDLE, RUN, FLUSH} state_t;
  localparam int NB_FLUSH  = (N_TAPS > 2) ? $clog2(N_TAPS) : 1;
  localparam int FLUSH_LEN = N_TAPS - 1;
  logic [NB_FLUSH-1:0] flush_q, flush_d;
`else
  typedef enum logic [1:0] {CLEAR, IDLE, RUN} state_t;
`endif

  state_t              state_q, state_d;
  logic [NB_LEN-1:0]   rem_q, rem_d;
  logic                done_q, done_d;
  logic [NB_DATA-1:0]  m_data_q;
  logic                m_valid_q, m_last_q;
  logic                space, fire, last_fire;

  // A fire is only ever issued when the output register can take the result.
  always_comb begin
    space      = !m_valid_q | i_m_ready;
    state_d    = state_q;
    rem_d      = rem_q;
    done_d     = 1'b0;
    fire       = 1'b0;
    last_fire  = 1'b0;
    o_s_ready  = 1'b0;
    o_fir_data = '0;
`ifdef FIR_CTRL_TAIL_FLUSH_EN
    flush_d    = flush_q;
`endif
    case (state_q)
      CLEAR: state_d = IDLE;
      IDLE: begin
        if (i_start) begin
          rem_d = i_frame_len;
          if (i_frame_len == '0) begin
            state_d = CLEAR;
            done_d  = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        o_s_ready  = space;
        o_fir_data = i_s_data;
        fire       = i_s_valid & space;
        if (fire) begin
          rem_d = rem_q - NB_LEN'(1);
          if (rem_q == NB_LEN'(1)) begin
`ifdef FIR_CTRL_TAIL_FLUSH_EN
            state_d = FLUSH;
            flush_d = NB_FLUSH'(FLUSH_LEN);
`else
            state_d   = CLEAR;
            done_d    = 1'b1;
            last_fire = 1'b1;
`endif
          end
        end
      end
`ifdef FIR_CTRL_TAIL_FLUSH_EN
      FLUSH: begin
        fire = space;
        if (fire) begin
          flush_d = flush_q - NB_FLUSH'(1);
          if (flush_q == NB_FLUSH'(1)) begin
            state_d   = CLEAR;
            done_d    = 1'b1;
            last_fire = 1'b1;
          end
        end
      end
`endif
      default: state_d = CLEAR;
    endcase
  end

  // Reset lands in CLEAR so the filter delay line is wiped after any abandoned frame.
  always_ff @(posedge clk or posedge i_srst) begin
    if (i_srst) begin
      state_q   <= CLEAR;
      rem_q     <= '0;
      done_q    <= 1'b0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
`ifdef FIR_CTRL_TAIL_FLUSH_EN
      flush_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
`ifdef FIR_CTRL_TAIL_FLUSH_EN
      flush_q <= flush_d;
`endif
      if (fire) begin
        m_data_q  <= i_fir_data;
        m_valid_q <= 1'b1;
        m_last_q  <= last_fire;
      end else if (i_m_ready) begin
        m_valid_q <= 1'b0;
        m_last_q  <= 1'b0;
      end
    end
  end

  assign o_fir_en   = fire;
  assign o_fir_srst = (state_q == CLEAR);
  assign o_busy     = (state_q != IDLE);
  assign o_done     = done_q;
  assign o_m_data   = m_data_q;
  assign o_m_valid  = m_valid_q;
  assign o_m_last   = m_last_q;

endmodule
